mem_arbiter: RTL and testbench

Registered arbiter between the instruction cache, data cache and the single-ported RAM. It serializes I-fetch and D-access requests onto the RAM bus, waits out RAM latency, and returns one-cycle `ihit`/`dhit` pulses with load data. These pulses feed the hazard unit's stall/enable logic. Data has priority, and a starvation guard guarantees forward progress for instruction fetch.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes I-fetch and D-access requests onto a single-ported RAM.
// Data has priority; a grant streak counter forces an I grant to avoid starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramerr
);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    RESP
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] streak;
  logic [3:0] streak_inc;
  logic       d_req;
  logic       i_starved;
  logic       grant_d;
  logic       grant_i;

  always_comb begin
    d_req      = dREN | dWEN;
    i_starved  = iREN && (streak == LIMIT);
    grant_d    = d_req && !i_starved;
    grant_i    = !grant_d && iREN;
    streak_inc = (streak >= LIMIT) ? LIMIT : streak + 4'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      streak   <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramerr   <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            streak   <= iREN ? streak_inc : 4'd0;
          end else if (grant_i) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            streak  <= 4'd0;
          end
        end
        IACC, DACC: begin
          if (ramstate == RS_ACCESS) begin
            state  <= RESP;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == IACC) begin
              ihit  <= 1'b1;
              iload <= ramload;
            end else begin
              dhit <= 1'b1;
              if (!ramWEN) dload <= ramload;
            end
          end else if (ramstate == RS_ERROR) begin
            // drop back and let the held request re-arbitrate
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            ramerr <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus randomized run
// against a transaction-level RAM/arbitration model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] RS_FREE   = 2'b00;
  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [1:0]  ramstate = RS_FREE;
  logic [31:0] ramload = '0;
  logic        ihit, dhit, ramREN, ramWEN, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramstate(ramstate), .ramload(ramload),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_i;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    bit          exp_ren;
    bit          exp_wen;
    logic [31:0] exp_iload;
    logic [31:0] exp_dload;
  } vec_t;

  vec_t vt[6];
  logic [31:0] mem [logic [31:0]];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    iREN     = v.is_i;
    iaddr    = v.is_i ? v.addr : 32'h0BAD0000;
    dREN     = v.ren;
    dWEN     = v.wen;
    daddr    = v.is_i ? 32'h0BAD0004 : v.addr;
    dstore   = v.wdata;
    ramstate = RS_FREE;
    tick;
    for (int k = 0; k <= v.busy; k++) begin
      chk1("vec_ramREN", ramREN, v.exp_ren);
      chk1("vec_ramWEN", ramWEN, v.exp_wen);
      chk32("vec_ramaddr", ramaddr, v.addr);
      if (v.exp_wen) chk32("vec_ramstore", ramstore, v.wdata);
      chk1("vec_nohit_busy", ihit | dhit, 1'b0);
      ramstate = (k < v.busy) ? RS_BUSY : RS_ACCESS;
      ramload  = v.rdata;
      tick;
    end
    chk1("vec_ihit", ihit, v.is_i);
    chk1("vec_dhit", dhit, !v.is_i);
    chk1("vec_strobe_low", ramREN | ramWEN, 1'b0);
    chk32("vec_iload", iload, v.exp_iload);
    chk32("vec_dload", dload, v.exp_dload);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = RS_FREE;
    ramload  = 32'h13579BDF;
    tick;
    chk1("vec_hit_one_cycle", ihit | dhit, 1'b0);
    chk32("vec_iload_hold", iload, v.exp_iload);
  endtask

  task automatic serve_one(input bit exp_i, input string nm,
                           input logic [31:0] ld);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick;
      seen = ramREN | ramWEN;
    end
    chk1({nm, "_grant_seen"}, seen, 1'b1);
    if (seen) begin
      chk32({nm, "_ramaddr"}, ramaddr, exp_i ? iaddr : daddr);
      ramstate = RS_ACCESS;
      ramload  = ld;
      tick;
      chk1({nm, "_ihit"}, ihit, exp_i);
      chk1({nm, "_dhit"}, dhit, !exp_i);
      ramstate = RS_FREE;
    end
  endtask

  bit          want_d, strobe, in_txn, give_err, cur_i, cur_w;
  bit          exp_ih, exp_dh, ih_now, dh_now, m_err;
  int          m_streak, busy_left, low_cnt, stall, op;
  logic [31:0] cur_addr, cur_store, rd, m_iload, m_dload;

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C220004, 0,
              1'b1, 1'b0, 32'h8C220004, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 1,
              1'b1, 1'b0, 32'h8C220004, 32'h12345678};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 32'h55555555, 3,
              1'b0, 1'b1, 32'h8C220004, 32'h12345678};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 0,
              1'b0, 1'b1, 32'h8C220004, 32'h12345678};
    vt[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hA5A5A5A5, 2,
              1'b1, 1'b0, 32'hA5A5A5A5, 32'h12345678};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 0,
              1'b1, 1'b0, 32'hA5A5A5A5, 32'h0};

    #12;
    chk1("rst_ihit", ihit, 1'b0);
    chk1("rst_dhit", dhit, 1'b0);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk1("rst_ramerr", ramerr, 1'b0);
    chk32("rst_iload", iload, 32'h0);
    chk32("rst_dload", dload, 32'h0);
    chk32("rst_ramaddr", ramaddr, 32'h0);
    chk32("rst_ramstore", ramstore, 32'h0);
    tick;
    nRST = 1'b1;
    tick;

    foreach (vt[i]) run_vec(vt[i]);

    // simultaneous requests: data first, then instruction
    iREN = 1'b1; iaddr = 32'h80;
    dREN = 1'b1; daddr = 32'h100;
    serve_one(1'b0, "simul_d", 32'h11110000);
    chk32("simul_dload", dload, 32'h11110000);
    dREN = 1'b0;
    serve_one(1'b1, "simul_i", 32'h22220000);
    chk32("simul_iload", iload, 32'h22220000);
    iREN = 1'b0;
    tick;

    // starvation guard: D,D,D,D,I,D
    iREN = 1'b1; iaddr = 32'h500;
    dREN = 1'b1; daddr = 32'h300;
    for (int g = 0; g < 6; g++)
      serve_one(g == LIMIT, "starve", 32'h30000000 + 32'(g));
    iREN = 1'b0; dREN = 1'b0;
    tick;
    tick;

    // RAM error then re-grant of the held read
    dREN = 1'b1; daddr = 32'h120;
    tick;
    chk1("err_ramREN", ramREN, 1'b1);
    ramstate = RS_ERROR;
    tick;
    chk1("err_no_dhit", dhit, 1'b0);
    chk1("err_no_ihit", ihit, 1'b0);
    chk1("err_ramerr", ramerr, 1'b1);
    chk1("err_strobe_low", ramREN, 1'b0);
    ramstate = RS_FREE;
    serve_one(1'b0, "err_regrant", 32'h0BADF00D);
    chk32("err_dload", dload, 32'h0BADF00D);
    chk1("err_ramerr_sticky", ramerr, 1'b1);
    dREN = 1'b0;
    tick;
    chk1("err_ramerr_sticky2", ramerr, 1'b1);

    // reset in the middle of a write
    dWEN = 1'b1; daddr = 32'h44; dstore = 32'h77;
    tick;
    chk1("mid_ramWEN", ramWEN, 1'b1);
    ramstate = RS_BUSY;
    #2 nRST = 1'b0;
    #1;
    chk1("mid_rst_ramWEN", ramWEN, 1'b0);
    chk1("mid_rst_ramREN", ramREN, 1'b0);
    chk1("mid_rst_ramerr", ramerr, 1'b0);
    chk1("mid_rst_hits", ihit | dhit, 1'b0);
    chk32("mid_rst_dload", dload, 32'h0);
    chk32("mid_rst_ramaddr", ramaddr, 32'h0);
    chk32("mid_rst_ramstore", ramstore, 32'h0);
    dWEN = 1'b0;
    ramstate = RS_FREE;
    tick;
    tick;
    chk1("mid_rst_no_hit", ihit | dhit, 1'b0);
    nRST = 1'b1;
    tick;
    chk1("post_rst_idle", ramREN | ramWEN, 1'b0);
    dREN = 1'b1; daddr = 32'h88;
    serve_one(1'b0, "post_rst", 32'h600D0001);
    chk32("post_rst_dload", dload, 32'h600D0001);
    dREN = 1'b0;
    tick;

    // randomized run against a transaction-level model
    m_iload = 32'h0; m_dload = 32'h600D0001; m_err = 1'b0;
    m_streak = 0; in_txn = 1'b0; exp_ih = 1'b0; exp_dh = 1'b0;
    low_cnt = 0; stall = 0; busy_left = 0; give_err = 1'b0;
    cur_i = 1'b0; cur_w = 1'b0; cur_addr = '0; cur_store = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      chk1("rnd_ihit", ihit, exp_ih);
      chk1("rnd_dhit", dhit, exp_dh);
      chk32("rnd_iload", iload, m_iload);
      chk32("rnd_dload", dload, m_dload);
      chk1("rnd_ramerr", ramerr, m_err);
      ih_now = exp_ih;
      dh_now = exp_dh;
      exp_ih = 1'b0;
      exp_dh = 1'b0;
      strobe = ramREN | ramWEN;
      if (low_cnt > 0) begin
        chk1("rnd_turnaround_low", strobe, 1'b0);
        low_cnt--;
      end else if (strobe && !in_txn) begin
        chk1("rnd_grant_has_req", iREN | dREN | dWEN, 1'b1);
        want_d = (dREN | dWEN) && !(iREN && m_streak == LIMIT);
        if (want_d && iREN) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
        else m_streak = 0;
        cur_i     = !want_d;
        cur_w     = want_d && dWEN;
        cur_addr  = want_d ? daddr : iaddr;
        cur_store = dstore;
        in_txn    = 1'b1;
        busy_left = int'($urandom_range(0, 3));
        give_err  = ($urandom_range(0, 9) == 0);
      end
      if (in_txn) begin
        chk1("rnd_ramREN", ramREN, !cur_w);
        chk1("rnd_ramWEN", ramWEN, cur_w);
        chk32("rnd_ramaddr", ramaddr, cur_addr);
        if (cur_w) chk32("rnd_ramstore", ramstore, cur_store);
        if (busy_left > 0) begin
          ramstate = RS_BUSY;
          busy_left--;
          ramload = $urandom;
        end else if (give_err) begin
          ramstate = RS_ERROR;
          ramload = $urandom;
          m_err = 1'b1;
          in_txn = 1'b0;
          low_cnt = 1;
        end else begin
          ramstate = RS_ACCESS;
          in_txn = 1'b0;
          low_cnt = 2;
          if (cur_w) begin
            mem[cur_addr] = cur_store;
            ramload = $urandom;
            exp_dh = 1'b1;
          end else begin
            rd = mem.exists(cur_addr) ? mem[cur_addr] : ~cur_addr;
            ramload = rd;
            if (cur_i) begin
              m_iload = rd;
              exp_ih = 1'b1;
            end else begin
              m_dload = rd;
              exp_dh = 1'b1;
            end
          end
        end
      end else begin
        ramstate = RS_FREE;
        ramload = $urandom;
      end
      if (ih_now) iREN = 1'b0;
      if (dh_now) begin
        dREN = 1'b0;
        dWEN = 1'b0;
      end
      if ((iREN | dREN | dWEN) && !ih_now && !dh_now) stall++;
      else stall = 0;
      if (stall > 200) begin
        checks++;
        errors++;
        $display("FAIL rnd_progress stalled=%0d required<=200", stall);
        break;
      end
      if (!iREN && $urandom_range(0, 2) == 0) begin
        iREN = 1'b1;
        iaddr = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
      end
      if (!(dREN | dWEN) && $urandom_range(0, 1) == 0) begin
        op = int'($urandom_range(0, 2));
        dREN = (op != 1);
        dWEN = (op != 0);
        daddr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        dstore = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
